// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared state encoding and default sizing for the slow-clock divider
package clkdiv_pkg;
  typedef logic state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN = 1'b1;
  localparam int CNT_W_DEF = 28;
  localparam int MIN_DIV_DEF = 2;
endpackage

// File: rtl/clkdiv_core.sv
// clkdiv_core: period counter, half-period compare and period-end detection
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] div_active,
  output logic             boundary,
  output logic             slowed_clk_next
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign boundary = enable && cnt_q == div_active - CNT_W'(1);
  assign slowed_clk_next = cnt_q >= (div_active >> 1);
  assign cnt_d = (clear || boundary) ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time divide-ratio, start/stop and one-shot control for slowed_clk.
// Optional CLKDIV_CTRL_PERIOD_COUNT_EN adds a saturating period_count output.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = 100000000,
  parameter int unsigned MIN_DIV = MIN_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_oneshot,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             slowed_clk,
  output logic             tick,
  output logic             done,
  output logic             busy
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
  ,
  output logic [31:0]      period_count
`endif
);
  localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);
  state_t state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d, pdiv_q, pdiv_d;
  logic os_q, os_d, pos_q, pos_d, pend_q, pend_d, stop_q, stop_d;
  logic run, go, acc, ok, boundary, slow_nx;
  assign run = state_q == RUN;
  assign go = !run && start && !stop;
  assign acc = cfg_valid && !pend_q;
  assign ok = cfg_div >= MIN_V;
  assign cfg_ready = !pend_q;
  assign busy = run;
  clkdiv_core #(.CNT_W(CNT_W)) u_core (
    .clk(clk),
    .rst(rst),
    .enable(run),
    .clear(!run),
    .div_active(div_q),
    .boundary(boundary),
    .slowed_clk_next(slow_nx)
  );
  // Accepts need !pend_q, so a boundary load and a new pending write never collide.
  always_comb begin
    state_d = go ? RUN : state_q;
    div_d = div_q;
    os_d = os_q;
    pdiv_d = pdiv_q;
    pos_d = pos_q;
    pend_d = pend_q;
    stop_d = stop_q || (run && stop && !boundary);
    if (boundary && pend_q) begin
      div_d = pdiv_q;
      os_d = pos_q;
      pend_d = 1'b0;
    end
    if (boundary && (os_q || stop_q || stop)) begin
      state_d = IDLE;
      stop_d = 1'b0;
    end
    if (acc && ok && run) begin
      pdiv_d = cfg_div;
      pos_d = cfg_oneshot;
      pend_d = 1'b1;
    end
    if (acc && ok && !run) begin
      div_d = cfg_div;
      os_d = cfg_oneshot;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= DEF_V;
      os_q <= 1'b0;
      pdiv_q <= '0;
      pos_q <= 1'b0;
      pend_q <= 1'b0;
      stop_q <= 1'b0;
      slowed_clk <= 1'b0;
      tick <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      os_q <= os_d;
      pdiv_q <= pdiv_d;
      pos_q <= pos_d;
      pend_q <= pend_d;
      stop_q <= stop_d;
      slowed_clk <= run && slow_nx;
      tick <= boundary;
      done <= boundary && os_q;
      cfg_err <= acc && !ok;
    end
  end
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
  logic [31:0] pc_q;
  always_ff @(posedge clk) begin
    if (rst || go) pc_q <= '0;
    else if (boundary && pc_q != '1) pc_q <= pc_q + 32'd1;
  end
  assign period_count = pc_q;
`endif
endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed test-plan sequences plus random traffic checked against a period-level model
module tb_clkdiv_ctrl;
  localparam int CNT_W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic cfg_oneshot = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic cfg_ready, cfg_err, slowed_clk, tick, done, busy;
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
  logic [31:0] period_count;
`endif
  int total = 0;
  int bad = 0;
  int m_div, m_pdiv, m_pos;
  bit m_run, m_os, m_pos_os, m_pend, m_sreq;
  bit e_slow, e_tick, e_done, e_err;
  logic [31:0] m_pc;

  clkdiv_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(10), .MIN_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div(cfg_div),
    .cfg_oneshot(cfg_oneshot),
    .cfg_err(cfg_err),
    .start(start),
    .stop(stop),
    .slowed_clk(slowed_clk),
    .tick(tick),
    .done(done),
    .busy(busy)
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
    ,
    .period_count(period_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Position m_pos within a period of m_div cycles; the low half is floor(div/2) cycles.
  task automatic model();
    bit last, acc, legal, was_os;
    if (rst) begin
      m_run = 0; m_pos = 0; m_div = 10; m_os = 0; m_pend = 0; m_sreq = 0; m_pc = 0;
      m_pdiv = 0; m_pos_os = 0;
      e_slow = 0; e_tick = 0; e_done = 0; e_err = 0;
      return;
    end
    last = m_run && (m_pos == m_div - 1);
    acc = cfg_valid && !m_pend;
    legal = int'(cfg_div) >= 2;
    e_slow = m_run && (m_pos >= m_div / 2);
    e_tick = last;
    e_done = last && m_os;
    e_err = acc && !legal;
    if (m_run) begin
      if (last) begin
        if (m_pc != 32'hFFFF_FFFF) m_pc++;
        was_os = m_os;
        if (m_pend) begin
          m_div = m_pdiv; m_os = m_pos_os; m_pend = 0;
        end
        if (was_os || m_sreq || stop) begin
          m_run = 0; m_sreq = 0;
        end
        m_pos = 0;
      end else begin
        m_pos++;
        if (stop) m_sreq = 1;
      end
      if (acc && legal) begin
        m_pdiv = int'(cfg_div); m_pos_os = cfg_oneshot; m_pend = 1;
      end
    end else begin
      if (acc && legal) begin
        m_div = int'(cfg_div); m_os = cfg_oneshot;
      end
      if (start && !stop) begin
        m_run = 1; m_pos = 0; m_pc = 0;
      end
    end
  endtask

  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    check("slowed_clk", 32'(slowed_clk), 32'(e_slow));
    check("tick", 32'(tick), 32'(e_tick));
    check("done", 32'(done), 32'(e_done));
    check("cfg_err", 32'(cfg_err), 32'(e_err));
    check("busy", 32'(busy), 32'(m_run));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
    check("period_count", period_count, m_pc);
`endif
  endtask

  task automatic idle_in();
    rst = 0; cfg_valid = 0; start = 0; stop = 0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic req(input int d, input bit os);
    cfg_valid = 1; cfg_div = CNT_W'(d); cfg_oneshot = os;
    cyc();
    cfg_valid = 0;
  endtask

  task automatic go_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_pos(input int p, input string tag);
    int i;
    for (i = 0; i < 300 && !(m_run && m_pos == p); i++) cyc();
    if (i == 300) check(tag, 32'(busy), 32'(0));
  endtask

  initial begin
    rst = 1;
    run_n(3);
    idle_in();
    run_n(2);
    go_start();
    run_n(25);
    wait_pos(3, "wait_mid");
    req(4, 0);
    cfg_valid = 1; cfg_div = 6;
    run_n(4);
    cfg_valid = 0;
    run_n(20);
    req(1, 0);
    run_n(3);
    wait_pos(1, "wait_stop3");
    stop = 1;
    cyc();
    stop = 0;
    run_n(12);
    req(7, 1);
    go_start();
    run_n(12);
    req(10, 0);
    go_start();
    wait_pos(3, "wait_cnt3");
    stop = 1;
    cyc();
    stop = 0;
    run_n(12);
    go_start();
    wait_pos(9, "wait_bnd");
    stop = 1;
    cyc();
    stop = 0;
    run_n(5);
    start = 1; stop = 1;
    cyc();
    idle_in();
    run_n(3);
    go_start();
    run_n(35);
    wait_pos(6, "wait_cnt6");
    rst = 1;
    cyc();
    idle_in();
    run_n(3);
    req(255, 1);
    go_start();
    run_n(260);
    req(2, 0);
    go_start();
    run_n(9);
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_div = ($urandom_range(0, 30) == 0) ? CNT_W'(255) : CNT_W'($urandom_range(0, 16));
      cfg_oneshot = ($urandom_range(0, 3) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
